regbank_arbiter: RTL and testbench
==================================

# regbank_arbiter

Shared 32-bit register bank with a round-robin access arbiter for the emulator datapath. Up to NREQ requesters (fetch, execute, debug, I/O) contend for a single access port into NREG positive-edge 32-bit flip-flop registers. One access is granted per cycle. Writes commit at the granting edge. Read data returns one cycle later, tagged to the requester that issued the read.

## Interface
- NREQ, 4, number of requesters; legal range 2..8.
- NREG, 16, number of 32-bit registers; power of two, 2..64.
- AW, 4, address width; must equal log2(NREG).

- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester access request; bit i belongs to requester i.
- wr  input  NREQ  per-requester op select: 1 = write, 0 = read; sampled only with req.
- addr  input  NREQ*AW  packed register addresses; requester i uses bits [i*AW +: AW].
- wdata  input  NREQ*32  packed write data; requester i uses bits [i*32 +: 32].
- gnt  output  NREQ  one-hot combinational grant for the current cycle; all zero when no req.
- rdata  output  32  registered read data.
- rvalid  output  NREQ  one-hot registered read-return strobe, one cycle after a read grant.

## Operation
- Priority pointer ptr, range 0..NREQ-1, is the highest-priority requester index.
- Search order: ptr, ptr+1, … mod NREQ. gnt is the first requester in that order with req=1.
- At each rising edge with a grant to requester k, ptr becomes (k+1) mod NREQ.
- With no grant, ptr holds.
- Write grant (wr[k]=1): bank[addr_k] <= wdata_k at that edge.
- Read grant (wr[k]=0):
  - rdata <= bank[addr_k] at that edge, taking the pre-edge value.
  - rvalid <= one-hot k at that edge.
- Cycle with no read grant: rvalid <= 0; rdata holds its last value.
- Only one access per cycle, so no intra-cycle read/write hazard.
- A read granted the cycle after a write to the same address returns the new value.
- Ungranted requesters are not queued. Each holds req (and its addr/wdata/wr) until it sees its gnt bit high in a cycle. The request is consumed at the end of that cycle.
- Fairness: a continuously requesting requester is granted within NREQ cycles.
- Address arithmetic is AW bits wide, with no bounds check; NREG = 2^AW makes every address valid.

## Timing
- Reset (reset_n low, asynchronous, effective immediately):
  - bank all 0, ptr = 0, rdata = 0, rvalid = 0.
  - gnt is forced to 0 while reset_n is low.
- First rising edge after reset_n deasserts: normal arbitration with requester 0 at top priority.
- Reset asserted mid-operation:
  - Any in-flight read return is dropped (rvalid cleared, no strobe later).
  - Any write not yet clocked is lost.
- Write latency: the value is visible to a read granted on the next cycle.
- Read latency: 1 cycle from the granting edge to rvalid/rdata; rvalid is high for exactly one cycle.
- Back-to-back reads by the same or different requesters give back-to-back rvalid pulses, each carrying the correct owner bit.
- gnt is a purely combinational function of req, ptr and reset_n; no combinational path from wr, addr or wdata to any output.
- Pointer wrap: grant to NREQ-1 sets ptr = 0.

## Test plan
- Reset and idle:
  - Hold reset_n=0 with req=4'b1111 -> gnt=0, rvalid=0, rdata=0.
  - Release with req=0 -> all outputs stay 0, and a read of any address after one request returns 0.
- Write then read (requester 2):
  - Write addr 5 = 32'h36D54B68.
  - Next cycle, requester 1 reads addr 5 -> rvalid=4'b0010 one cycle later, rdata=32'h36D54B68.
  - No rvalid follows the write cycle.
- Round robin: req=4'b1111 held constant, all reads -> gnt sequence 0001, 0010, 0100, 1000, 0001 (wrap). rvalid follows the same sequence delayed by one cycle.
- Priority skip: ptr=1 (after a grant to 0) with req=4'b1001 -> gnt=4'b1000, then ptr=0 and gnt=4'b0001.
- Overwrite and hold:
  - Write addr 3 = 32'hAC6D2299, then addr 3 = 32'hAB28D21B on consecutive cycles.
  - Read addr 3 -> 32'hAB28D21B.
  - Idle cycles after the read -> rdata stays 32'hAB28D21B with rvalid=0.
- Reset mid-read: assert reset_n=0 between the read-grant edge and the next edge -> rvalid drops to 0 immediately and never pulses. A subsequent read of the previously written address returns 0.

Source files
------------

// File: rtl/regbank_arbiter.sv
// regbank_arbiter: shared bank of NREG 32-bit registers behind one access port, arbitrated
// round-robin among NREQ requesters. One access is granted per cycle. A write commits at
// the granting edge. A read returns registered data one cycle later, tagged with a one-hot
// owner strobe.
//
// Ports:
//   clk_i     clock; all state changes on the rising edge
//   rst_ni    asynchronous active-low reset
//   req_i     per-requester access request
//   wr_i      per-requester op select (1 = write, 0 = read); only looked at with req
//   addr_i    packed addresses; requester i uses [i*AW +: AW]
//   wdata_i   packed write data; requester i uses [i*32 +: 32]
//   gnt_o     one-hot combinational grant for this cycle; zero when idle or in reset
//   rdata_o   registered read data; holds its value between reads
//   rvalid_o  one-hot registered read-return strobe, one cycle after a read grant
module regbank_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned NREG = 16,
  parameter int unsigned AW   = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    wr_i,
  input  logic [NREQ*AW-1:0] addr_i,
  input  logic [NREQ*32-1:0] wdata_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic [31:0]        rdata_o,
  output logic [NREQ-1:0]    rvalid_o
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_any;
  logic [NREQ-1:0] gnt;

  logic            sel_wr;
  logic [AW-1:0]   sel_addr;
  logic [31:0]     sel_wdata;
  logic            rd_fire;

  logic [31:0]     bank_q [NREG];
  logic [31:0]     rdata_q;
  logic [NREQ-1:0] rvalid_q, rvalid_d;

  // Round-robin search starting at ptr_q. Depends only on req_i, ptr_q and rst_ni.
  always_comb begin
    int unsigned idx;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr_q) + i) % NREQ;
      if (!gnt_any && req_i[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
        gnt_any  = 1'b1;
      end
    end
    if (!rst_ni) begin
      gnt     = '0;
      gnt_any = 1'b0;
    end
  end

  assign gnt_o = gnt;

  // Steer the granted requester's operands onto the single bank port.
  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_wr    = wr_i[i];
        sel_addr  = addr_i[i*AW +: AW];
        sel_wdata = wdata_i[i*32 +: 32];
      end
    end
  end

  assign rd_fire = gnt_any && !sel_wr;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + PW'(1);
    end
  end

  assign rvalid_d = rd_fire ? gnt : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
      // Pre-edge bank value; a write in the same cycle is impossible (one access/cycle).
      if (rd_fire) begin
        rdata_q <= bank_q[sel_addr];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NREG); i++) begin
        bank_q[i] <= '0;
      end
    end else if (gnt_any && sel_wr) begin
      bank_q[sel_addr] <= sel_wdata;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;

endmodule

// File: tb/tb_regbank_arbiter.sv
// Bench for regbank_arbiter: directed steps followed by randomized traffic, all checked
// against a behavioural model of the register bank and round-robin pointer.
module tb_regbank_arbiter;

  localparam int NREQ = 4;
  localparam int NREG = 16;
  localparam int AW   = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     wr;
  logic [NREQ*AW-1:0]  addr;
  logic [NREQ*32-1:0]  wdata;
  logic [NREQ-1:0]     gnt;
  logic [31:0]         rdata;
  logic [NREQ-1:0]     rvalid;

  regbank_arbiter #(
    .NREQ (NREQ),
    .NREG (NREG),
    .AW   (AW)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req_i    (req),
    .wr_i     (wr),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .gnt_o    (gnt),
    .rdata_o  (rdata),
    .rvalid_o (rvalid)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state.
  logic [31:0]     m_bank [NREG];
  int              m_ptr;
  logic [31:0]     m_rdata;
  logic [NREQ-1:0] m_rvalid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_bank[i] = '0;
    m_ptr    = 0;
    m_rdata  = '0;
    m_rvalid = '0;
  endtask

  // Whoever is first at or after the pointer, wrapping, wins.
  function automatic int model_pick(input logic [NREQ-1:0] r);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
    end
    return -1;
  endfunction

  // One bus cycle: drive, check grant, clock, update model, check registered outputs.
  task automatic cycle(input string tag, input logic [NREQ-1:0] r, input logic [NREQ-1:0] w,
                       input logic [NREQ*AW-1:0] a, input logic [NREQ*32-1:0] d,
                       output int k);
    logic [NREQ-1:0] eg;
    req   = r;
    wr    = w;
    addr  = a;
    wdata = d;
    k  = model_pick(r);
    eg = (k < 0) ? '0 : NREQ'(1) << k;
    #1;
    chk({tag, "/gnt"}, 32'(gnt), 32'(eg));
    @(posedge clk);
    if (k >= 0) begin
      if (w[k]) begin
        m_bank[a[k*AW +: AW]] = d[k*32 +: 32];
        m_rvalid = '0;
      end else begin
        m_rdata  = m_bank[a[k*AW +: AW]];
        m_rvalid = eg;
      end
      m_ptr = (k + 1) % NREQ;
    end else begin
      m_rvalid = '0;
    end
    #1;
    chk({tag, "/rvalid"}, 32'(rvalid), 32'(m_rvalid));
    chk({tag, "/rdata"}, rdata, m_rdata);
  endtask

  task automatic op(input string tag, input int i, input logic w, input logic [AW-1:0] a,
                    input logic [31:0] d);
    logic [NREQ*AW-1:0] pa;
    logic [NREQ*32-1:0] pd;
    logic [NREQ-1:0]    pw;
    int k;
    pa = '0;
    pd = '0;
    pw = '0;
    pa[i*AW +: AW] = a;
    pd[i*32 +: 32] = d;
    pw[i] = w;
    cycle(tag, NREQ'(1) << i, pw, pa, pd, k);
  endtask

  task automatic idle(input string tag);
    int k;
    cycle(tag, '0, '0, '0, '0, k);
  endtask

  // Apply reset right now (asynchronously), hold across an edge, release after it.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk({tag, "/gnt"}, 32'(gnt), 32'h0);
    chk({tag, "/rvalid"}, 32'(rvalid), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [NREQ-1:0]    rr_tab [5];
  logic [NREQ-1:0]    preq, pwr;
  logic [NREQ*AW-1:0] paddr;
  logic [NREQ*32-1:0] pwdata;
  int                 wait_c [NREQ];
  int                 k;

  initial begin
    rr_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    model_reset();

    // Reset with every requester asking.
    rst_n = 1'b0;
    req   = '1;
    wr    = '0;
    addr  = '0;
    wdata = '0;
    #1;
    chk("rst/gnt", 32'(gnt), 32'h0);
    chk("rst/rvalid", 32'(rvalid), 32'h0);
    chk("rst/rdata", rdata, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = '0;
    idle("idle");
    op("rd_after_rst", 0, 1'b0, 4'd7, 32'h0);
    chk("rd_after_rst/const", rdata, 32'h0);

    // Write by requester 2, read back by requester 1.
    op("wr2", 2, 1'b1, 4'd5, 32'h36D54B68);
    chk("wr2/no_rvalid", 32'(rvalid), 32'h0);
    op("rd1", 1, 1'b0, 4'd5, 32'h0);
    chk("rd1/owner", 32'(rvalid), 32'h2);
    chk("rd1/data", rdata, 32'h36D54B68);

    // Round robin from a fresh pointer, all four reading.
    do_reset("rst2");
    for (int j = 0; j < 5; j++) begin
      cycle("rr", 4'b1111, 4'b0000, '0, '0, k);
      chk("rr/seq", 32'(rvalid), 32'(rr_tab[j]));
    end

    // Pointer is now 1: requester 3 beats 0, then 0 wins after the wrap.
    cycle("skip_a", 4'b1001, 4'b0000, '0, '0, k);
    chk("skip_a/owner", 32'(rvalid), 32'h8);
    cycle("skip_b", 4'b1001, 4'b0000, '0, '0, k);
    chk("skip_b/owner", 32'(rvalid), 32'h1);

    // Overwrite then read, then idle hold.
    op("ow1", 0, 1'b1, 4'd3, 32'hAC6D2299);
    op("ow2", 0, 1'b1, 4'd3, 32'hAB28D21B);
    op("ow_rd", 0, 1'b0, 4'd3, 32'h0);
    chk("ow_rd/data", rdata, 32'hAB28D21B);
    idle("hold1");
    idle("hold2");
    chk("hold/data", rdata, 32'hAB28D21B);
    chk("hold/rvalid", 32'(rvalid), 32'h0);

    // Reset landing between a read-grant edge and the next edge.
    op("mr_wr", 0, 1'b1, 4'd9, 32'h5A5AC3C3);
    req  = 4'b0001;
    wr   = 4'b0000;
    addr = '0;
    addr[3:0] = 4'd9;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr/rvalid", 32'(rvalid), 32'h0);
    chk("mr/rdata", rdata, 32'h0);
    chk("mr/gnt", 32'(gnt), 32'h0);
    model_reset();
    req = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle("mr_idle");
    op("mr_rd", 0, 1'b0, 4'd9, 32'h0);
    chk("mr_rd/data", rdata, 32'h0);

    // Randomized traffic: requests hold until granted; check fairness bound too.
    preq   = '0;
    pwr    = '0;
    paddr  = '0;
    pwdata = '0;
    for (int i = 0; i < NREQ; i++) wait_c[i] = 0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!preq[i] && $urandom_range(0, 99) < 60) begin
          preq[i]              = 1'b1;
          pwr[i]               = 1'($urandom_range(0, 1));
          paddr[i*AW +: AW]    = AW'($urandom_range(0, 7));
          pwdata[i*32 +: 32]   = $urandom;
          wait_c[i]            = 0;
        end
        if (preq[i]) wait_c[i]++;
      end
      cycle("rand", preq, pwr, paddr, pwdata, k);
      if (k >= 0) begin
        chk("rand/fair", 32'(wait_c[k] <= NREQ), 32'h1);
        preq[k] = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
